axi_req_arbiter: RTL and testbench

AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

---
 rtl/axi_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_axi_req_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_arbiter.sv
// Single-outstanding arbiter that merges IFU reads, LSU reads and LSU stores onto one AXI port toward the MMU.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin between contending reads (default: LSU wins).
module axi_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         satp,

    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,

    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [2:0]          lsu_arsize,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,

    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,

    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arsize,
    output logic [7:0]          m_arlen,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [31:0]         m_arsatp,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,

    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [31:0]         m_awsatp,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_IFU_R = 2'd1,
        GNT_LSU_R = 2'd2,
        GNT_LSU_W = 2'd3
    } state_t;

    state_t      state_r;
    logic        ar_done_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic [31:0] satp_r;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_gnt_lsu_r;
`endif

    logic        pick_lsu_s;
    logic        rd_ifu_s;
    logic        rd_lsu_s;
    logic        wr_s;

    // Read winner for the next IDLE decision
    always_comb begin
        pick_lsu_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (ifu_arvalid && lsu_arvalid) begin
            pick_lsu_s = !last_gnt_lsu_r;
        end else begin
            pick_lsu_s = lsu_arvalid;
        end
`else
        pick_lsu_s = lsu_arvalid;
`endif
    end

    // Grant FSM with per-channel handshake flags and latched satp
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ar_done_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            satp_r    <= 32'h0000_0000;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_lsu_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    ar_done_r <= 1'b0;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    if (lsu_awvalid && lsu_wvalid) begin
                        state_r <= GNT_LSU_W;
                        satp_r  <= satp;
                    end else if (ifu_arvalid || lsu_arvalid) begin
                        state_r <= pick_lsu_s ? GNT_LSU_R : GNT_IFU_R;
                        satp_r  <= satp;
`ifdef ARB_ROUND_ROBIN_EN
                        last_gnt_lsu_r <= pick_lsu_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_IFU_R, GNT_LSU_R: begin
                    if (m_arvalid && m_arready) begin
                        ar_done_r <= 1'b1;
                    end
                    if (m_rvalid && m_rready) begin
                        state_r <= IDLE;
                    end
                end
                GNT_LSU_W: begin
                    if (m_awvalid && m_awready) begin
                        aw_done_r <= 1'b1;
                    end
                    if (m_wvalid && m_wready) begin
                        w_done_r <= 1'b1;
                    end
                    if (m_bvalid && m_bready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Grant decode; squashing it during rst silences every handshake output
    always_comb begin
        rd_ifu_s = 1'b0;
        rd_lsu_s = 1'b0;
        wr_s     = 1'b0;
        if (rst) begin
            rd_ifu_s = 1'b0;
        end else begin
            case (state_r)
                GNT_IFU_R: rd_ifu_s = 1'b1;
                GNT_LSU_R: rd_lsu_s = 1'b1;
                GNT_LSU_W: wr_s     = 1'b1;
                default:   rd_ifu_s = 1'b0;
            endcase
        end
    end

    assign m_araddr    = rd_lsu_s ? lsu_araddr : ifu_araddr;
    assign m_arsize    = rd_lsu_s ? lsu_arsize : 3'b010;
    assign m_arlen     = 8'd0;
    assign m_arburst   = 2'b01;
    assign m_arvalid   = ((rd_ifu_s && ifu_arvalid) || (rd_lsu_s && lsu_arvalid)) && !ar_done_r;
    assign ifu_arready = rd_ifu_s && !ar_done_r && m_arready;
    assign lsu_arready = rd_lsu_s && !ar_done_r && m_arready;
    assign m_arsatp    = satp_r;

    assign m_rready    = (rd_ifu_s && ifu_rready) || (rd_lsu_s && lsu_rready);
    assign ifu_rvalid  = rd_ifu_s && m_rvalid;
    assign ifu_rdata   = m_rdata;
    assign ifu_rresp   = m_rresp;
    assign lsu_rvalid  = rd_lsu_s && m_rvalid;
    assign lsu_rdata   = m_rdata;
    assign lsu_rresp   = m_rresp;

    assign m_awaddr    = lsu_awaddr;
    assign m_awvalid   = wr_s && lsu_awvalid && !aw_done_r;
    assign lsu_awready = wr_s && !aw_done_r && m_awready;
    assign m_awsatp    = satp_r;
    assign m_wdata     = lsu_wdata;
    assign m_wstrb     = lsu_wstrb;
    assign m_wvalid    = wr_s && lsu_wvalid && !w_done_r;
    assign lsu_wready  = wr_s && !w_done_r && m_wready;
    assign lsu_bvalid  = wr_s && m_bvalid;
    assign lsu_bresp   = m_bresp;
    assign m_bready    = wr_s && lsu_bready;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Bench for axi_req_arbiter: vector table, directed corner sequences and randomized transactions
// checked against a transaction-level priority model (honours ARB_ROUND_ROBIN_EN).
module tb_axi_req_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int G_IFU  = 0;
    localparam int G_LSU  = 1;
    localparam int G_W    = 2;

    logic clk, rst;
    logic [31:0] satp;
    logic [ADDR_W-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, m_araddr, m_awaddr;
    logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [DATA_W-1:0] ifu_rdata, lsu_rdata, lsu_wdata, m_rdata, m_wdata;
    logic [1:0] ifu_rresp, lsu_rresp, lsu_bresp, m_rresp, m_bresp, m_arburst;
    logic [2:0] lsu_arsize, m_arsize;
    logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [DATA_W/8-1:0] lsu_wstrb, m_wstrb;
    logic [7:0] m_arlen;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_arsatp, m_awsatp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

    axi_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .satp(satp),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arsatp(m_arsatp),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awsatp(m_awsatp),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_last = G_IFU;

    logic [31:0] t_ia, t_la, t_wa, t_wd, t_rd, t_sp, t_sp2;
    logic [2:0]  t_lsz;
    logic [3:0]  t_ws;
    logic [1:0]  t_resp;

    typedef struct {
        bit iv;
        bit lv;
        bit sv;
        int exp_fix;
        int exp_rr;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_payload();
        t_ia   = $urandom;
        t_la   = $urandom;
        t_wa   = $urandom;
        t_wd   = $urandom;
        t_rd   = $urandom;
        t_sp   = $urandom;
        t_sp2  = $urandom;
        t_lsz  = 3'($urandom_range(0, 2));
        t_ws   = 4'($urandom);
        t_resp = 2'($urandom);
    endtask

    // Priority rule: complete store first, then contended reads by build, else the lone reader
    function automatic int predict(input bit iv, input bit lv, input bit sv);
        if (sv) return G_W;
        if (iv && lv) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (model_last == G_IFU) ? G_LSU : G_IFU;
`else
            return G_LSU;
`endif
        end
        return lv ? G_LSU : G_IFU;
    endfunction

    task automatic run_arb(input string tag, input bit iv, input bit lv, input bit sv, input int exp,
                           input int ar_dly, input int aw_dly, input int w_dly, input int rsp_dly,
                           input bit keep_ifu);
        bit rd_g, ifu_g, lsu_g, ar_hs, aw_hs, w_hs, nar, naw, nw, done;
        int wait_c;
        logic [31:0] gaddr;
        logic [2:0]  gsize;
        rd_g  = (exp != G_W);
        ifu_g = (exp == G_IFU);
        lsu_g = (exp == G_LSU);
        gaddr = ifu_g ? t_ia : t_la;
        gsize = ifu_g ? 3'b010 : t_lsz;
        ifu_araddr = t_ia; ifu_arvalid = iv;
        lsu_araddr = t_la; lsu_arsize = t_lsz; lsu_arvalid = lv;
        lsu_awaddr = t_wa; lsu_wdata = t_wd; lsu_wstrb = t_ws;
        lsu_awvalid = sv; lsu_wvalid = sv;
        satp = t_sp;
        #1;
        chk({tag, " latency m_arvalid"}, 32'(m_arvalid), 32'(1'b0));
        chk({tag, " latency m_awvalid"}, 32'(m_awvalid), 32'(1'b0));
        tick();
        satp = t_sp2;
        ar_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0; done = 1'b0; wait_c = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            m_arready = (c >= ar_dly);
            m_awready = (c >= aw_dly);
            m_wready  = (c >= w_dly);
            m_rvalid  = rd_g && ar_hs && (wait_c >= rsp_dly);
            m_bvalid  = !rd_g && aw_hs && w_hs && (wait_c >= rsp_dly);
            m_rdata = t_rd; m_rresp = t_resp; m_bresp = t_resp;
            ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
            #1;
            chk({tag, " m_arsatp"}, m_arsatp, t_sp);
            chk({tag, " m_awsatp"}, m_awsatp, t_sp);
            if (rd_g) begin
                chk({tag, " m_arvalid"}, 32'(m_arvalid), 32'(!ar_hs));
                if (!ar_hs) begin
                    chk({tag, " m_araddr"}, m_araddr, gaddr);
                    chk({tag, " m_arsize"}, 32'(m_arsize), 32'(gsize));
                    chk({tag, " m_arlen"}, 32'(m_arlen), 32'(8'd0));
                    chk({tag, " m_arburst"}, 32'(m_arburst), 32'(2'b01));
                end
                chk({tag, " ifu_arready"}, 32'(ifu_arready), 32'(ifu_g && !ar_hs && m_arready));
                chk({tag, " lsu_arready"}, 32'(lsu_arready), 32'(lsu_g && !ar_hs && m_arready));
                chk({tag, " m_rready"}, 32'(m_rready), 32'(1'b1));
                chk({tag, " ifu_rvalid"}, 32'(ifu_rvalid), 32'(ifu_g && m_rvalid));
                chk({tag, " lsu_rvalid"}, 32'(lsu_rvalid), 32'(lsu_g && m_rvalid));
                if (m_rvalid) begin
                    chk({tag, " rdata"}, ifu_g ? ifu_rdata : lsu_rdata, t_rd);
                    chk({tag, " rresp"}, 32'(ifu_g ? ifu_rresp : lsu_rresp), 32'(t_resp));
                end
                chk({tag, " m_awvalid idle"}, 32'(m_awvalid), 32'(1'b0));
                chk({tag, " lsu_awready idle"}, 32'(lsu_awready), 32'(1'b0));
                chk({tag, " lsu_wready idle"}, 32'(lsu_wready), 32'(1'b0));
                chk({tag, " lsu_bvalid idle"}, 32'(lsu_bvalid), 32'(1'b0));
            end else begin
                chk({tag, " m_awvalid"}, 32'(m_awvalid), 32'(!aw_hs));
                chk({tag, " m_wvalid"}, 32'(m_wvalid), 32'(!w_hs));
                if (!aw_hs) chk({tag, " m_awaddr"}, m_awaddr, t_wa);
                if (!w_hs) begin
                    chk({tag, " m_wdata"}, m_wdata, t_wd);
                    chk({tag, " m_wstrb"}, 32'(m_wstrb), 32'(t_ws));
                end
                chk({tag, " lsu_awready"}, 32'(lsu_awready), 32'(!aw_hs && m_awready));
                chk({tag, " lsu_wready"}, 32'(lsu_wready), 32'(!w_hs && m_wready));
                chk({tag, " lsu_bvalid"}, 32'(lsu_bvalid), 32'(m_bvalid));
                chk({tag, " m_bready"}, 32'(m_bready), 32'(1'b1));
                if (m_bvalid) chk({tag, " bresp"}, 32'(lsu_bresp), 32'(t_resp));
                chk({tag, " m_arvalid idle"}, 32'(m_arvalid), 32'(1'b0));
                chk({tag, " ifu_arready idle"}, 32'(ifu_arready), 32'(1'b0));
                chk({tag, " lsu_arready idle"}, 32'(lsu_arready), 32'(1'b0));
                chk({tag, " ifu_rvalid idle"}, 32'(ifu_rvalid), 32'(1'b0));
                chk({tag, " lsu_rvalid idle"}, 32'(lsu_rvalid), 32'(1'b0));
            end
            nar  = rd_g && !ar_hs && m_arready;
            naw  = !rd_g && !aw_hs && m_awready;
            nw   = !rd_g && !w_hs && m_wready;
            done = m_rvalid || m_bvalid;
            tick();
            if (rd_g ? ar_hs : (aw_hs && w_hs)) wait_c++;
            if (nar) begin
                ar_hs = 1'b1;
                if (ifu_g) ifu_arvalid = 1'b0; else lsu_arvalid = 1'b0;
            end
            if (naw) begin aw_hs = 1'b1; lsu_awvalid = 1'b0; end
            if (nw)  begin w_hs  = 1'b1; lsu_wvalid  = 1'b0; end
        end
        if (!done) chk({tag, " completion within budget"}, 32'(done), 32'(1'b1));
        if (!keep_ifu) ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_rvalid = 1'b0; m_bvalid = 1'b0;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        #1;
        chk({tag, " back to idle m_arvalid"}, 32'(m_arvalid), 32'(1'b0));
        chk({tag, " back to idle m_awvalid"}, 32'(m_awvalid), 32'(1'b0));
        chk({tag, " back to idle m_wvalid"}, 32'(m_wvalid), 32'(1'b0));
        if (exp != G_W) model_last = exp;
        if (!keep_ifu) tick();
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, " m_arvalid"}, 32'(m_arvalid), 32'(1'b0));
        chk({tag, " m_awvalid"}, 32'(m_awvalid), 32'(1'b0));
        chk({tag, " m_wvalid"}, 32'(m_wvalid), 32'(1'b0));
        chk({tag, " m_rready"}, 32'(m_rready), 32'(1'b0));
        chk({tag, " m_bready"}, 32'(m_bready), 32'(1'b0));
        chk({tag, " ifu_arready"}, 32'(ifu_arready), 32'(1'b0));
        chk({tag, " lsu_arready"}, 32'(lsu_arready), 32'(1'b0));
        chk({tag, " lsu_awready"}, 32'(lsu_awready), 32'(1'b0));
        chk({tag, " lsu_wready"}, 32'(lsu_wready), 32'(1'b0));
        chk({tag, " ifu_rvalid"}, 32'(ifu_rvalid), 32'(1'b0));
        chk({tag, " lsu_rvalid"}, 32'(lsu_rvalid), 32'(1'b0));
        chk({tag, " lsu_bvalid"}, 32'(lsu_bvalid), 32'(1'b0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, r;
        bit iv, lv, sv;
        tbl[0] = '{1'b1, 1'b0, 1'b0, G_IFU, G_IFU};
        tbl[1] = '{1'b0, 1'b1, 1'b0, G_LSU, G_LSU};
        tbl[2] = '{1'b1, 1'b1, 1'b0, G_LSU, G_IFU};
        tbl[3] = '{1'b0, 1'b0, 1'b1, G_W,   G_W};
        tbl[4] = '{1'b1, 1'b1, 1'b1, G_W,   G_W};
        tbl[5] = '{1'b1, 1'b0, 1'b1, G_W,   G_W};
        tbl[6] = '{1'b1, 1'b1, 1'b0, G_LSU, G_LSU};
        tbl[7] = '{1'b1, 1'b1, 1'b0, G_LSU, G_IFU};
        tbl[8] = '{1'b1, 1'b1, 1'b0, G_LSU, G_LSU};

        // Reset held with live-looking inputs: every handshake output must stay low
        rst = 1'b1; satp = 32'h8000_0123;
        ifu_araddr = '0; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arsize = 3'b000; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        lsu_awaddr = '0; lsu_awvalid = 1'b1; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b1;
        lsu_bready = 1'b1;
        m_arready = 1'b1; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00; m_bvalid = 1'b1;
        tick();
        tick();
        #1;
        chk_all_quiet("reset held");
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_rvalid = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset m_arsatp", m_arsatp, 32'h0000_0000);
        chk("reset m_awsatp", m_awsatp, 32'h0000_0000);
        tick();

        for (int i = 0; i < 9; i++) begin
            rand_payload();
`ifdef ARB_ROUND_ROBIN_EN
            e = tbl[i].exp_rr;
`else
            e = tbl[i].exp_fix;
`endif
            run_arb($sformatf("vec%0d", i), tbl[i].iv, tbl[i].lv, tbl[i].sv, e,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), 1'b0);
        end

        // Lone fetch with known address and instruction word
        rand_payload();
        t_ia = 32'h8000_0000; t_rd = 32'h0000_0013;
        run_arb("ifu fetch", 1'b1, 1'b0, 1'b0, G_IFU, 0, 0, 0, 2, 1'b0);

        // satp rewritten mid-read must not reach the latched copy
        rand_payload();
        t_sp = 32'h8000_0123; t_sp2 = 32'h0000_0000;
        run_arb("satp hold", 1'b0, 1'b1, 1'b0, G_LSU, 2, 0, 0, 3, 1'b0);

        // Store where w completes two cycles before aw
        rand_payload();
        t_wa = 32'h8000_1000; t_wd = 32'hDEAD_BEEF; t_ws = 4'hF;
        run_arb("store split", 1'b0, 1'b0, 1'b1, G_W, 0, 2, 0, 1, 1'b0);

        // Store beats a waiting fetch, which is served right after
        rand_payload();
        run_arb("store first", 1'b1, 1'b0, 1'b1, G_W, 0, 1, 2, 1, 1'b1);
        run_arb("fetch after store", 1'b1, 1'b0, 1'b0, G_IFU, 1, 0, 0, 0, 1'b0);

        // Reset during an LSU read whose address already went out
        rand_payload();
        lsu_araddr = t_la; lsu_arsize = t_lsz; lsu_arvalid = 1'b1; satp = t_sp;
        tick();
        m_arready = 1'b1;
        #1;
        chk("mid reset lsu_arready", 32'(lsu_arready), 32'(1'b1));
        tick();
        lsu_arvalid = 1'b0; m_arready = 1'b0;
        rst = 1'b1; m_rvalid = 1'b1; m_rdata = t_rd;
        #1;
        chk_all_quiet("mid reset");
        tick();
        rst = 1'b0;
        #1;
        chk("post reset lsu_rvalid", 32'(lsu_rvalid), 32'(1'b0));
        chk("post reset m_rready", 32'(m_rready), 32'(1'b0));
        chk("post reset m_arsatp", m_arsatp, 32'h0000_0000);
        m_rvalid = 1'b0;
        model_last = G_IFU;
        tick();
        rand_payload();
        run_arb("fetch after reset", 1'b1, 1'b0, 1'b0, G_IFU, 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rand_payload();
            r  = $urandom_range(1, 7);
            iv = r[0]; lv = r[1]; sv = r[2];
            e  = predict(iv, lv, sv);
            run_arb($sformatf("rnd%0d", i), iv, lv, sv, e,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
